// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: registered operand-forwarding selects,
// load-use stall sequencing and branch/jump redirect-flush sequencing.
// Holds the only pipeline-control FSM in the core.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // squash cycles after a redirect, including the redirect cycle (1..7)
    parameter int LOAD_LAT     = 1,   // bubble cycles for a load-use hazard (1..7)
    parameter int CNT_W        = 16   // stall performance counter width
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use1,
    input  logic             i_id_use2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memtoreg,
    input  logic             i_ex_valid,
    input  logic             i_ex_branch,
    input  logic             i_ex_jump,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_regwrite,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_stall,
    output logic             o_bubble_ex,
    output logic             o_flush,
    output logic             o_pc_sel,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Loaded with the number of further cycles the sequence still lasts.
    localparam logic [2:0] FLUSH_EXTRA = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] LOAD_EXTRA  = 3'(LOAD_LAT - 1);

    state_t     state;
    logic [2:0] seq_cnt;
    logic       redirect;
    logic       loaduse;
    logic       rs1_hit;
    logic       rs2_hit;

    assign rs1_hit  = i_id_use1 && (i_id_rs1 == i_ex_rd);
    assign rs2_hit  = i_id_use2 && (i_id_rs2 == i_ex_rd);
    assign redirect = i_ex_valid && (i_ex_branch || i_ex_jump);
    assign loaduse  = i_ex_valid && i_ex_memtoreg && i_ex_regwrite &&
                      (i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    assign o_state = state;

    // EX match beats MEM match; x0 and unused operands always read the regfile.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_rs && rs != 5'd0) begin
            if (i_ex_regwrite && i_ex_valid && i_ex_rd == rs)
                sel = FWD_MEM;
            else if (i_mem_regwrite && i_mem_rd == rs)
                sel = FWD_WB;
        end
        return sel;
    endfunction

    // Pipeline-control strobes from the current state; inputs only matter in RUN.
    always_comb begin
        o_stall     = 1'b0;
        o_bubble_ex = 1'b0;
        o_flush     = 1'b0;
        o_pc_sel    = 1'b0;
        if (i_reset) begin
            case (state)
                RUN: begin
                    // ID holds a wrong-path instruction on a redirect, so no stall.
                    if (redirect) begin
                        o_pc_sel    = 1'b1;
                        o_flush     = 1'b1;
                        o_bubble_ex = 1'b1;
                    end else if (loaduse) begin
                        o_stall     = 1'b1;
                        o_bubble_ex = 1'b1;
                    end
                end
                LSTALL: begin
                    o_stall     = 1'b1;
                    o_bubble_ex = 1'b1;
                end
                FLUSH: begin
                    o_flush     = 1'b1;
                    o_bubble_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM: RUN -> LSTALL/FLUSH for the extra cycles, then back to RUN.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state   <= RUN;
            seq_cnt <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        if (FLUSH_CYCLES > 1) begin
                            state   <= FLUSH;
                            seq_cnt <= FLUSH_EXTRA;
                        end
                    end else if (loaduse) begin
                        if (LOAD_LAT > 1) begin
                            state   <= LSTALL;
                            seq_cnt <= LOAD_EXTRA;
                        end
                    end
                end
                LSTALL, FLUSH: begin
                    if (seq_cnt <= 3'd1) begin
                        state   <= RUN;
                        seq_cnt <= 3'd0;
                    end else begin
                        seq_cnt <= seq_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    seq_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Forwarding selects for the instruction entering EX; a bubble reads the regfile.
    always_ff @(posedge i_clk) begin
        if (!i_reset || o_stall || o_bubble_ex) begin
            o_fwd_a <= FWD_RF;
            o_fwd_b <= FWD_RF;
        end else begin
            o_fwd_a <= fwd_sel(i_id_rs1, i_id_use1);
            o_fwd_b <= fwd_sel(i_id_rs2, i_id_use2);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            o_stall_cnt <= '0;
        else if (o_stall && o_stall_cnt != {CNT_W{1'b1}})
            o_stall_cnt <= o_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: two instances share stimulus (A: FLUSH=2 LOAD=1,
// B: FLUSH=5 LOAD=3, both with a 4-bit stall counter). Directed vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_ex_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd;
        logic       exrw, exm2r, exv, exbr, exj;
        logic [4:0] memrd;
        logic       memrw;
    } in_t;

    typedef struct packed {
        logic       stall, bub, flush, pc;
        logic [1:0] fa, fb, st;
        logic [3:0] cnt;
    } exp_t;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    in_t s;
    logic [1:0] a_fa, a_fb, a_st, b_fa, b_fb, b_st;
    logic       a_stall, a_bub, a_fl, a_pc, b_stall, b_bub, b_fl, b_pc;
    logic [3:0] a_cnt, b_cnt;

    ex_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_LAT(1), .CNT_W(4)) dut_a (
        .i_clk(i_clk), .i_reset(s.rst),
        .i_id_rs1(s.rs1), .i_id_rs2(s.rs2), .i_id_use1(s.u1), .i_id_use2(s.u2),
        .i_ex_rd(s.exrd), .i_ex_regwrite(s.exrw), .i_ex_memtoreg(s.exm2r),
        .i_ex_valid(s.exv), .i_ex_branch(s.exbr), .i_ex_jump(s.exj),
        .i_mem_rd(s.memrd), .i_mem_regwrite(s.memrw),
        .o_fwd_a(a_fa), .o_fwd_b(a_fb), .o_stall(a_stall), .o_bubble_ex(a_bub),
        .o_flush(a_fl), .o_pc_sel(a_pc), .o_state(a_st), .o_stall_cnt(a_cnt));

    ex_hazard_ctrl #(.FLUSH_CYCLES(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .i_clk(i_clk), .i_reset(s.rst),
        .i_id_rs1(s.rs1), .i_id_rs2(s.rs2), .i_id_use1(s.u1), .i_id_use2(s.u2),
        .i_ex_rd(s.exrd), .i_ex_regwrite(s.exrw), .i_ex_memtoreg(s.exm2r),
        .i_ex_valid(s.exv), .i_ex_branch(s.exbr), .i_ex_jump(s.exj),
        .i_mem_rd(s.memrd), .i_mem_regwrite(s.memrw),
        .o_fwd_a(b_fa), .o_fwd_b(b_fb), .o_stall(b_stall), .o_bubble_ex(b_bub),
        .o_flush(b_fl), .o_pc_sel(b_pc), .o_state(b_st), .o_stall_cnt(b_cnt));

    exp_t  qa[$], qb[$];
    string qn[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic exp_t e(logic st_, logic bu, logic fl, logic pc,
                               logic [1:0] fa, logic [1:0] fb, logic [1:0] sta, logic [3:0] cnt);
        exp_t r;
        r.stall = st_; r.bub = bu; r.flush = fl; r.pc = pc;
        r.fa = fa; r.fb = fb; r.st = sta; r.cnt = cnt;
        return r;
    endfunction

    function automatic in_t idle();
        in_t r;
        r = '0;
        r.rst = 1'b1;
        return r;
    endfunction

    // EX load to x3, ID reads x3 through rs2
    function automatic in_t lu();
        in_t r;
        r = idle();
        r.exv = 1'b1; r.exm2r = 1'b1; r.exrw = 1'b1; r.exrd = 5'd3;
        r.rs2 = 5'd3; r.u2 = 1'b1;
        return r;
    endfunction

    task automatic apply(input string nm, input in_t v, input exp_t ea, input exp_t eb);
        @(posedge i_clk);
        #1;
        s = v;
        qa.push_back(ea);
        qb.push_back(eb);
        qn.push_back(nm);
    endtask

    task automatic cmp(input string nm, input string inst, input exp_t act, input exp_t ex);
        n_cmp++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s/%s: got stall=%b bub=%b flush=%b pc=%b fa=%b fb=%b st=%0d cnt=%0d, want stall=%b bub=%b flush=%b pc=%b fa=%b fb=%b st=%0d cnt=%0d",
                     nm, inst, act.stall, act.bub, act.flush, act.pc, act.fa, act.fb, act.st, act.cnt,
                     ex.stall, ex.bub, ex.flush, ex.pc, ex.fa, ex.fb, ex.st, ex.cnt);
        end
    endtask

    // Monitor: every cycle the DUTs present a response for the vector driven this cycle.
    always @(negedge i_clk) begin
        if (qa.size() != 0 && qb.size() != 0 && qn.size() != 0) begin
            exp_t  ea, eb;
            string nm;
            ea = qa.pop_front();
            eb = qb.pop_front();
            nm = qn.pop_front();
            cmp(nm, "A", e(a_stall, a_bub, a_fl, a_pc, a_fa, a_fb, a_st, a_cnt), ea);
            cmp(nm, "B", e(b_stall, b_bub, b_fl, b_pc, b_fa, b_fb, b_st, b_cnt), eb);
        end
    end

    initial begin
        in_t  v;
        exp_t z;
        z = '0;

        // Reset asserted with a load-use hazard on the inputs
        v = lu();
        v.rst = 1'b0;
        s = v;
        repeat (2) @(posedge i_clk);
        apply("reset0", v, z, z);
        apply("reset1", v, z, z);

        // Forwarding: EX and MEM both write x5, ID reads x5/x5
        v = idle();
        v.exv = 1'b1; v.exrw = 1'b1; v.exrd = 5'd5; v.memrw = 1'b1; v.memrd = 5'd5;
        v.rs1 = 5'd5; v.rs2 = 5'd5; v.u1 = 1'b1; v.u2 = 1'b1;
        apply("fwd_setup", v, z, z);
        // Only MEM x7 matches rs2
        v = idle();
        v.exv = 1'b1; v.exrw = 1'b1; v.exrd = 5'd9; v.memrw = 1'b1; v.memrd = 5'd7;
        v.rs1 = 5'd5; v.rs2 = 5'd7; v.u1 = 1'b1; v.u2 = 1'b1;
        apply("fwd_ex_prio", v, e(0,0,0,0,2'b01,2'b01,0,0), e(0,0,0,0,2'b01,2'b01,0,0));
        // x0 matches everywhere
        v = idle();
        v.exv = 1'b1; v.exrw = 1'b1; v.memrw = 1'b1; v.u1 = 1'b1; v.u2 = 1'b1;
        apply("fwd_mem", v, e(0,0,0,0,2'b00,2'b10,0,0), e(0,0,0,0,2'b00,2'b10,0,0));
        // x4 matches EX on both, but rs1 is unused
        v = idle();
        v.exv = 1'b1; v.exrw = 1'b1; v.exrd = 5'd4; v.rs1 = 5'd4; v.rs2 = 5'd4; v.u2 = 1'b1;
        apply("fwd_x0", v, z, z);

        // Load-use: A stalls one cycle, B stalls three
        apply("lu_0", lu(), e(1,1,0,0,2'b00,2'b01,0,0), e(1,1,0,0,2'b00,2'b01,0,0));
        apply("lu_1", idle(), e(0,0,0,0,0,0,0,1), e(1,1,0,0,0,0,1,1));
        apply("lu_2", idle(), e(0,0,0,0,0,0,0,1), e(1,1,0,0,0,0,1,2));
        apply("lu_end", idle(), e(0,0,0,0,0,0,0,1), e(0,0,0,0,0,0,0,3));

        // Taken branch, then a jump that must be ignored during the flush
        v = idle(); v.exv = 1'b1; v.exbr = 1'b1;
        apply("br_0", v, e(0,1,1,1,0,0,0,1), e(0,1,1,1,0,0,0,3));
        v = idle(); v.exv = 1'b1; v.exj = 1'b1;
        apply("br_1", v, e(0,1,1,0,0,0,2,1), e(0,1,1,0,0,0,2,3));
        apply("br_2", idle(), e(0,0,0,0,0,0,0,1), e(0,1,1,0,0,0,2,3));
        apply("br_3", idle(), e(0,0,0,0,0,0,0,1), e(0,1,1,0,0,0,2,3));
        apply("br_4", idle(), e(0,0,0,0,0,0,0,1), e(0,1,1,0,0,0,2,3));
        apply("br_end", idle(), e(0,0,0,0,0,0,0,1), e(0,0,0,0,0,0,0,3));

        // Redirect and load-use together: redirect only, counter untouched
        v = lu(); v.exbr = 1'b1; v.rs1 = 5'd3; v.u1 = 1'b1;
        apply("rd_lu_0", v, e(0,1,1,1,0,0,0,1), e(0,1,1,1,0,0,0,3));
        apply("rd_lu_1", idle(), e(0,1,1,0,0,0,2,1), e(0,1,1,0,0,0,2,3));
        // Reset at flush cycle 2 of B
        v = idle(); v.rst = 1'b0;
        apply("rst_flush", v, e(0,0,0,0,0,0,0,1), e(0,0,0,0,0,0,2,3));
        apply("post_rst", idle(), z, z);

        // Continuous load-use: counter climbs to 15 and saturates
        for (int k = 0; k < 20; k++) begin
            logic [3:0] c;
            c = (k > 15) ? 4'd15 : 4'(k);
            apply($sformatf("sat_%0d", k), lu(), e(1,1,0,0,0,0,0,c),
                  e(1,1,0,0,0,0,(k % 3 == 0) ? 2'd0 : 2'd1, c));
        end
        apply("sat_tail", idle(), e(0,0,0,0,0,0,0,15), e(1,1,0,0,0,0,1,15));
        apply("sat_hold", idle(), e(0,0,0,0,0,0,0,15), e(0,0,0,0,0,0,0,15));

        for (int i = 0; i < 20 && qa.size() != 0; i++) @(negedge i_clk);
        #2;
        if (qa.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses pending, want 0", qa.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the EX stage of the RV32IC 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates registered ALU operand-forwarding selects, load-use stalls, and branch/jump redirect-and-flush sequencing.
- Sits beside the ALU, driven by ID/EX/MEM/WB pipeline-register fields and by the ALU branch-taken output.
- Owns the only pipeline-control FSM in the core.

Parameters:
- FLUSH_CYCLES, 2, total cycles of wrong-path squash after a redirect, counting the redirect cycle; legal range 1..7.
- LOAD_LAT, 1, bubble cycles inserted for a load-use hazard; legal range 1..7.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, synchronous, active-low.
- i_id_rs1  in  5  ID-stage source register 1.
- i_id_rs2  in  5  ID-stage source register 2.
- i_id_use1  in  1  ID instruction reads rs1.
- i_id_use2  in  1  ID instruction reads rs2.
- i_ex_rd  in  5  EX-stage destination.
- i_ex_regwrite  in  1  EX instruction writes rd.
- i_ex_memtoreg  in  1  EX instruction is a load.
- i_ex_valid  in  1  EX holds a real instruction (not a bubble).
- i_ex_branch  in  1  ALU branch-taken for the EX instruction.
- i_ex_jump  in  1  EX instruction is JAL/JALR.
- i_mem_rd  in  5  MEM-stage destination.
- i_mem_regwrite  in  1  MEM instruction writes rd.
- o_fwd_a  out  2  ALU operand A select: 00 regfile, 01 MEM ALUOutput, 10 WB value.
- o_fwd_b  out  2  ALU operand B select, same encoding as o_fwd_a.
- o_stall  out  1  hold PC and the IF/ID register.
- o_bubble_ex  out  1  load a NOP into the ID/EX register.
- o_flush  out  1  kill the IF/ID contents.
- o_pc_sel  out  1  PC mux takes the EX target (ALUOutput).
- o_state  out  2  FSM state: 0 RUN, 1 LSTALL, 2 FLUSH.
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_stall=1.

Behaviour:
- Reset: while i_reset=0 at a rising edge, the FSM goes to RUN, counters clear, o_fwd_a/o_fwd_b go to 00, and o_stall_cnt goes to 0. Every combinational output (o_stall, o_bubble_ex, o_flush, o_pc_sel) is forced to 0 while i_reset=0. Reset mid-stall or mid-flush abandons the sequence.
- Hazard terms:
  - redirect = i_ex_valid & (i_ex_branch | i_ex_jump).
  - loaduse = i_ex_valid & i_ex_memtoreg & i_ex_regwrite & i_ex_rd!=0 & ((i_id_use1 & i_id_rs1==i_ex_rd) | (i_id_use2 & i_id_rs2==i_ex_rd)).
- RUN:
  - If redirect: o_pc_sel=1, o_flush=1, o_bubble_ex=1 in the same cycle. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
  - Else if loaduse: o_stall=1, o_bubble_ex=1 in the same cycle. Go to LSTALL if LOAD_LAT>1, else stay in RUN.
  - Redirect beats loaduse, because the ID instruction is wrong-path.
- LSTALL:
  - Holds o_stall=1 and o_bubble_ex=1 for LOAD_LAT-1 further cycles, tracked by a down-counter, then returns to RUN.
  - A redirect is impossible here, since EX holds a bubble; i_ex_* are ignored.
- FLUSH:
  - Holds o_bubble_ex=1 and o_flush=1 for FLUSH_CYCLES-1 further cycles, then returns to RUN.
  - o_pc_sel=0. i_ex_* are ignored, so wrong-path instructions never redirect or stall.
- Forwarding (registered, applied during the next cycle's EX):
  - At each edge with o_stall=0 and o_bubble_ex=0:
    - o_fwd_a = 01 if i_ex_regwrite & i_ex_valid & i_ex_rd!=0 & i_ex_rd==i_id_rs1.
    - Else o_fwd_a = 10 if i_mem_regwrite & i_mem_rd!=0 & i_mem_rd==i_id_rs1.
    - Else o_fwd_a = 00.
    - o_fwd_b is computed the same way using rs2.
  - The EX match has priority over the MEM match.
  - If the use bit is 0, the select is 00.
  - On a bubble cycle both selects register 00.
  - x0 is never forwarded.
- o_stall_cnt: increments on each cycle with o_stall=1 and saturates at all-ones.
- o_state reflects the registered FSM state.

Test Plan:
- Reset: i_reset=0 for 2 cycles while loaduse conditions are present -> all outputs 0, o_state=0, o_stall_cnt=0.
- Forwarding: EX rd=5 (regwrite), MEM rd=5 (regwrite), ID rs1=5, rs2=5 -> next cycle o_fwd_a=01 and o_fwd_b=01. Then with only MEM rd=7 matching rs2=7 -> o_fwd_b=10. With rd=0 matching -> 00.
- Load-use, LOAD_LAT=1: EX load rd=3, ID rs2=3 use2=1 -> one cycle of o_stall=1 and o_bubble_ex=1, then RUN, o_stall_cnt=1. Repeat with LOAD_LAT=3 -> 3 stall cycles, o_state=1 for cycles 2-3.
- Branch taken, FLUSH_CYCLES=2: i_ex_valid=1, i_ex_branch=1 -> cycle 0: o_pc_sel=1, o_flush=1, o_bubble_ex=1. Cycle 1: o_flush=1, o_bubble_ex=1, o_pc_sel=0, with i_ex_jump=1 ignored. Cycle 2: RUN.
- Simultaneous redirect and loaduse -> redirect sequence only, o_stall=0, o_stall_cnt unchanged.
- Reset during FLUSH (FLUSH_CYCLES=5, reset at cycle 2) -> RUN the next cycle, no residual o_flush. Also force 2^CNT_W stall cycles -> o_stall_cnt holds at all-ones.
